// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared across the Y86 pipeline and the data-memory
// responder. It holds the icode values that touch data memory, the
// processor status codes, and the responder FSM state type.
package y86_pkg;

  // Instructions that access data memory
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Processor status codes
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/y86_dmem_array.sv
// y86_dmem_array: byte-addressed data storage. No reset and no fault
// checking; the caller only writes in-range addresses.
// Ports:
//   i_clk    clock, writes on rising edge
//   i_raddr  byte address of the 8-byte little-endian read (combinational)
//   o_rdata  bytes raddr..raddr+7, raddr in bits [7:0]
//   i_we     write enable
//   i_waddr  byte address of the 8-byte little-endian write
//   i_wdata  write data, bits [7:0] go to waddr
module y86_dmem_array #(
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_raddr,
  output logic [63:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [63:0]   i_wdata
);

  logic [7:0]  r_mem [MEM_BYTES];
  logic [AW:0] w_ridx [8];
  logic [AW:0] w_widx [8];

  // One extra index bit so the sum never wraps; lanes past the end of the
  // array read as zero and are never written.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_ridx[i] = {1'b0, i_raddr} + (AW+1)'(i);
      w_widx[i] = {1'b0, i_waddr} + (AW+1)'(i);
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      if (w_ridx[i] < (AW+1)'(MEM_BYTES))
        o_rdata[8*i +: 8] = r_mem[w_ridx[i][AW-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < 8; i++) begin
        if (w_widx[i] < (AW+1)'(MEM_BYTES))
          r_mem[w_widx[i][AW-1:0]] <= i_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/y86_dmem_responder.sv
// y86_dmem_responder: data-memory responder for the Y86 memory stage.
// Accepts one 8-byte load or store at a time and answers after LATENCY
// cycles, flagging out-of-range addresses so the stage can raise SADR.
// Optional build macro: DMEM_ALIGN_CHECK_EN (misaligned addresses fault too).
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_req_valid/o_req_ready request handshake
//   i_req_write             1 = store, 0 = load
//   i_req_addr, i_req_wdata byte address and store data
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_rdata             load data (little-endian), 0 for stores/faults
//   o_rsp_err               address fault
//
// state   | meaning
// IDLE    | ready for a request
// BUSY    | access latency countdown; commit/capture when counter hits 0
// RESP    | response held until rsp_ready
module y86_dmem_responder
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic [63:0]   r_rsp_rdata;
  logic          r_rsp_err;

  logic          w_fault;
  logic          w_done;
  logic          w_we;
  logic [63:0]   w_rd;

  // Full-width compare: a huge address can never alias into the array.
  always_comb begin
    w_fault = (r_addr > 64'(MEM_BYTES - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    w_fault = w_fault | (r_addr[2:0] != 3'b000);
`endif
  end

  assign w_done = (r_state == ST_BUSY) && (r_cnt == '0);
  assign w_we   = w_done && r_write && !w_fault;

  y86_dmem_array #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_raddr (r_addr[AW-1:0]),
    .o_rdata (w_rd),
    .i_we    (w_we),
    .i_waddr (r_addr[AW-1:0]),
    .i_wdata (r_wdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_write     <= i_req_write;
            r_addr      <= i_req_addr;
            r_wdata     <= i_req_wdata;
            r_cnt       <= CW'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            // Store commits at this same edge through w_we, so a following
            // load always sees it.
            r_rsp_err   <= w_fault;
            r_rsp_rdata <= (w_fault || r_write) ? 64'd0 : w_rd;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule
